// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin arbiter that turns set/clear/toggle commands
// from NREQ requesters into single-cycle S/R pulses for a bank of NBITS SR
// flip-flops. A shadow copy of the bank is used to resolve toggles, and the
// block never drives S and R together on the same bit.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = $clog2(NBITS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [IDXW*NREQ-1:0]      req_idx,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      clr_all,
  output logic [NBITS-1:0]          s_out,
  output logic [NBITS-1:0]          r_out,
  output logic [NBITS-1:0]          q_shadow,
  output logic                      grant_valid,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      err
);

  localparam int GIDW = $clog2(NREQ);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  logic [GIDW-1:0]  ptr_reg, ptr_next;
  logic [NBITS-1:0] s_reg, s_next;
  logic [NBITS-1:0] r_reg, r_next;
  logic [NBITS-1:0] q_reg, q_next;
  logic             gv_reg, gv_next;
  logic [GIDW-1:0]  gid_reg, gid_next;
  logic             err_reg, err_next;

  logic             win_found;
  logic [GIDW-1:0]  win_id;
  int               cand;
  logic             grant_en;
  logic [1:0]       sel_op;
  logic [IDXW-1:0]  sel_idx;
  logic             idx_ok;
  logic [NBITS-1:0] bit_mask;
  logic             bit_is_set;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr_reg) + k) % NREQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = GIDW'(cand);
      end
    end
  end

  // Grants are suppressed during bulk clear and while reset is held low.
  assign grant_en = win_found && !clr_all && reset;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_en && (win_id == GIDW'(gi));
    end
  endgenerate

  // Decode the winning command; an out-of-range index yields an empty mask.
  always_comb begin
    sel_op     = req_op[int'(win_id)*2 +: 2];
    sel_idx    = req_idx[int'(win_id)*IDXW +: IDXW];
    idx_ok     = int'(sel_idx) < NBITS;
    bit_mask   = idx_ok ? (NBITS'(1) << sel_idx) : '0;
    bit_is_set = |(q_reg & bit_mask);
  end

  // Next-state: pulses default to zero; clr_all beats any pending request.
  always_comb begin
    s_next   = '0;
    r_next   = '0;
    q_next   = q_reg;
    gv_next  = 1'b0;
    gid_next = gid_reg;
    err_next = 1'b0;
    ptr_next = ptr_reg;
    if (clr_all) begin
      r_next = '1;
      q_next = '0;
    end else if (grant_en) begin
      gv_next  = 1'b1;
      gid_next = win_id;
      ptr_next = (win_id == GIDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      if (sel_op == OP_NOP || !idx_ok) begin
        err_next = 1'b1;
      end else if (sel_op == OP_SET || (sel_op == OP_TOGGLE && !bit_is_set)) begin
        s_next = bit_mask;
        q_next = q_reg | bit_mask;
      end else begin
        // OP_CLEAR, or OP_TOGGLE of a bit that is currently set
        r_next = bit_mask;
        q_next = q_reg & ~bit_mask;
      end
    end
  end

  // State registers, cleared asynchronously so pulses die mid-cycle on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= '0;
      s_reg   <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      gv_reg  <= 1'b0;
      gid_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      s_reg   <= s_next;
      r_reg   <= r_next;
      q_reg   <= q_next;
      gv_reg  <= gv_next;
      gid_reg <= gid_next;
      err_reg <= err_next;
    end
  end

  assign s_out       = s_reg;
  assign r_out       = r_reg;
  assign q_shadow    = q_reg;
  assign grant_valid = gv_reg;
  assign grant_id    = gid_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Testbench for sr_bank_arbiter: scoreboard of expected outputs fed by a
// small reference model, plus direct checks of the documented scenarios.
module tb_sr_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IDXW  = 4;   // wide enough to express idx = 9

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0;
  logic [2*NREQ-1:0]    req_op    = '0;
  logic [IDXW*NREQ-1:0] req_idx   = '0;
  logic                 clr_all   = 1'b0;
  logic [NREQ-1:0]      req_ready;
  logic [NBITS-1:0]     s_out, r_out, q_shadow;
  logic                 grant_valid;
  logic [1:0]           grant_id;
  logic                 err;

  sr_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_idx(req_idx), .req_ready(req_ready), .clr_all(clr_all),
    .s_out(s_out), .r_out(r_out), .q_shadow(q_shadow),
    .grant_valid(grant_valid), .grant_id(grant_id), .err(err)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] r;
    logic [7:0] q;
    logic       gv;
    logic [1:0] gid;
    logic       err;
  } out_t;

  typedef struct packed {
    logic [3:0] ready;
    out_t       o;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int         m_ptr = 0;
  logic [7:0] m_q   = '0;
  logic [1:0] m_gid = '0;

  logic [3:0] obs_ready;
  out_t       obs_out;
  exp_t       e;

  // Predict req_ready for this cycle and the registered outputs after the edge.
  task automatic model_push(input logic [3:0] v, input logic [7:0] op,
                            input logic [15:0] idx, input logic clr);
    exp_t x;
    int w;
    int bi;
    logic [1:0] o;
    x = '0;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && v[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    x.o.q   = m_q;
    x.o.gid = m_gid;
    if (clr) begin
      x.o.r = 8'hFF;
      x.o.q = 8'h00;
    end else if (w >= 0) begin
      x.ready[w] = 1'b1;
      x.o.gv  = 1'b1;
      x.o.gid = 2'(w);
      m_ptr   = (w + 1) % NREQ;
      o  = op[2*w +: 2];
      bi = int'(idx[IDXW*w +: IDXW]);
      if (o == 2'b00 || bi >= NBITS) begin
        x.o.err = 1'b1;
      end else begin
        if (o == 2'b11) o = m_q[bi] ? 2'b01 : 2'b10;
        if (o == 2'b10) begin x.o.s[bi] = 1'b1; x.o.q[bi] = 1'b1; end
        else            begin x.o.r[bi] = 1'b1; x.o.q[bi] = 1'b0; end
      end
    end
    m_q   = x.o.q;
    m_gid = x.o.gid;
    sb.push_back(x);
  endtask

  // Drive one cycle of stimulus (starting just after a rising edge) and
  // capture req_ready before the next edge and the outputs after it.
  task automatic step(input logic [3:0] v, input logic [7:0] op,
                      input logic [15:0] idx, input logic clr);
    req_valid = v;
    req_op    = op;
    req_idx   = idx;
    clr_all   = clr;
    model_push(v, op, idx, clr);
    @(negedge clk);
    obs_ready = req_ready;
    @(posedge clk);
    #1;
    obs_out = {s_out, r_out, q_shadow, grant_valid, grant_id, err};
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    req_op    = 8'hAA;
    @(posedge clk);
    #1;
    obs_out = {s_out, r_out, q_shadow, grant_valid, grant_id, err};
    n_cmp++;
    if (obs_out !== out_t'(0) || req_ready !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_state: got out=%h ready=%b want out=0 ready=0", obs_out, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_set();
    step(4'b0001, 8'h02, 16'h0003, 1'b0);
    e = sb.pop_front();
    n_cmp += 3;
    if (obs_ready !== e.ready) begin
      n_bad++; $display("FAIL set_ready: got %b want %b", obs_ready, e.ready);
    end
    if (obs_out !== e.o) begin
      n_bad++; $display("FAIL set_out: got %h want %h", obs_out, e.o);
    end
    if (s_out !== 8'h08 || r_out !== 8'h00 || q_shadow !== 8'h08 ||
        grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL set_bit3: got s=%h r=%h q=%h gv=%b gid=%0d want s=08 r=00 q=08 gv=1 gid=0",
               s_out, r_out, q_shadow, grant_valid, grant_id);
    end
    step(4'b0000, 8'h00, 16'h0000, 1'b0);
    e = sb.pop_front();
    n_cmp += 2;
    if (obs_out !== e.o) begin
      n_bad++; $display("FAIL set_idle_out: got %h want %h", obs_out, e.o);
    end
    if (s_out !== 8'h00) begin
      n_bad++; $display("FAIL set_pulse_end: got s=%h want s=00", s_out);
    end
  endtask

  task automatic test_round_robin();
    // pointer sits at 1 after the single grant to requester 0
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 8'hAA, 16'h3210, 1'b0);
      e = sb.pop_front();
      n_cmp += 3;
      if (obs_ready !== e.ready || !$onehot(obs_ready)) begin
        n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, obs_ready, e.ready);
      end
      if (obs_out !== e.o) begin
        n_bad++; $display("FAIL rr_out[%0d]: got %h want %h", k, obs_out, e.o);
      end
      if (grant_id !== 2'((1 + k) % 4) || grant_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: got gid=%0d gv=%b want gid=%0d gv=1",
                 k, grant_id, grant_valid, (1 + k) % 4);
      end
    end
  endtask

  task automatic test_toggle();
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 8'h30, 16'h0500, 1'b0);
      e = sb.pop_front();
      n_cmp += 3;
      if (obs_ready !== e.ready) begin
        n_bad++; $display("FAIL tog_ready[%0d]: got %b want %b", k, obs_ready, e.ready);
      end
      if (obs_out !== e.o) begin
        n_bad++; $display("FAIL tog_out[%0d]: got %h want %h", k, obs_out, e.o);
      end
      // expected on bit 5: S, R, S and shadow 1, 0, 1
      if (s_out[5] !== (k != 1) || r_out[5] !== (k == 1) ||
          q_shadow[5] !== (k != 1) || (s_out & r_out) !== 8'h00) begin
        n_bad++;
        $display("FAIL tog_bit5[%0d]: got s5=%b r5=%b q5=%b s&r=%h want s5=%b r5=%b q5=%b s&r=00",
                 k, s_out[5], r_out[5], q_shadow[5], s_out & r_out, k != 1, k == 1, k != 1);
      end
    end
  endtask

  task automatic test_err();
    logic [7:0]  ops [2];
    logic [15:0] ids [2];
    ops[0] = 8'h08; ids[0] = 16'h0090;   // set, idx 9 out of range
    ops[1] = 8'h00; ids[1] = 16'h0020;   // nop, idx 2
    for (int k = 0; k < 2; k++) begin
      step(4'b0010, ops[k], ids[k], 1'b0);
      e = sb.pop_front();
      n_cmp += 3;
      if (obs_ready !== e.ready) begin
        n_bad++; $display("FAIL err_ready[%0d]: got %b want %b", k, obs_ready, e.ready);
      end
      if (obs_out !== e.o) begin
        n_bad++; $display("FAIL err_out[%0d]: got %h want %h", k, obs_out, e.o);
      end
      if (err !== 1'b1 || s_out !== 8'h00 || r_out !== 8'h00 || q_shadow !== 8'h2F ||
          grant_valid !== 1'b1 || grant_id !== 2'd1) begin
        n_bad++;
        $display("FAIL err_pulse[%0d]: got err=%b s=%h r=%h q=%h gv=%b gid=%0d want err=1 s=00 r=00 q=2f gv=1 gid=1",
                 k, err, s_out, r_out, q_shadow, grant_valid, grant_id);
      end
    end
    step(4'b0000, 8'h00, 16'h0000, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (obs_out !== e.o || err !== 1'b0) begin
      n_bad++; $display("FAIL err_clears: got %h want %h", obs_out, e.o);
    end
  endtask

  task automatic test_clr_all();
    logic [15:0] ids [4];
    ids[0] = 16'h0000; ids[1] = 16'h0002; ids[2] = 16'h0005; ids[3] = 16'h0007;
    step(4'b0000, 8'h00, 16'h0000, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (obs_out !== e.o) begin
      n_bad++; $display("FAIL clr_prep: got %h want %h", obs_out, e.o);
    end
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 8'h02, ids[k], 1'b0);
      e = sb.pop_front();
      n_cmp++;
      if (obs_out !== e.o) begin
        n_bad++; $display("FAIL clr_load[%0d]: got %h want %h", k, obs_out, e.o);
      end
    end
    n_cmp++;
    if (q_shadow !== 8'hA5) begin
      n_bad++; $display("FAIL clr_pattern: got q=%h want q=a5", q_shadow);
    end
    step(4'hF, 8'hAA, 16'h3210, 1'b1);
    e = sb.pop_front();
    n_cmp += 2;
    if (obs_ready !== 4'h0 || obs_ready !== e.ready) begin
      n_bad++; $display("FAIL clr_ready: got %b want 0000", obs_ready);
    end
    if (obs_out !== e.o || r_out !== 8'hFF || s_out !== 8'h00 ||
        q_shadow !== 8'h00 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_pulse: got s=%h r=%h q=%h gv=%b want s=00 r=ff q=00 gv=0",
               s_out, r_out, q_shadow, grant_valid);
    end
    // pointer was left at 1 by the grants to requester 0; no dead cycle
    step(4'hF, 8'hAA, 16'h3210, 1'b0);
    e = sb.pop_front();
    n_cmp += 2;
    if (obs_ready !== e.ready || obs_ready !== 4'b0010) begin
      n_bad++; $display("FAIL clr_resume_ready: got %b want 0010", obs_ready);
    end
    if (obs_out !== e.o || grant_valid !== 1'b1 || grant_id !== 2'd1) begin
      n_bad++; $display("FAIL clr_resume_out: got %h want %h", obs_out, e.o);
    end
  endtask

  task automatic test_async_reset();
    step(4'b1000, 8'h80, 16'h4000, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if (obs_out !== e.o || s_out !== 8'h10) begin
      n_bad++; $display("FAIL ar_pulse: got %h (s=%h) want %h (s=10)", obs_out, s_out, e.o);
    end
    req_valid = 4'hF;
    req_op    = 8'hAA;
    #2;
    reset = 1'b0;
    #1;
    obs_out = {s_out, r_out, q_shadow, grant_valid, grant_id, err};
    n_cmp++;
    if (obs_out !== out_t'(0) || req_ready !== 4'h0) begin
      n_bad++;
      $display("FAIL ar_immediate: got out=%h ready=%b want out=0 ready=0", obs_out, req_ready);
    end
    m_ptr = 0; m_q = '0; m_gid = '0;
    sb.delete();
    @(posedge clk);
    #1;
    n_cmp++;
    if (s_out !== 8'h00 || q_shadow !== 8'h00 || req_ready !== 4'h0) begin
      n_bad++; $display("FAIL ar_held: got s=%h q=%h ready=%b want 00 00 0000", s_out, q_shadow, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(4'hF, 8'hAA, 16'h3210, 1'b0);
    e = sb.pop_front();
    n_cmp += 2;
    if (obs_ready !== e.ready || obs_ready !== 4'b0001) begin
      n_bad++; $display("FAIL ar_first_ready: got %b want 0001", obs_ready);
    end
    if (obs_out !== e.o || grant_id !== 2'd0 || s_out !== 8'h01) begin
      n_bad++; $display("FAIL ar_first_grant: got %h want %h", obs_out, e.o);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_round_robin();
    test_toggle();
    test_err();
    test_clr_all();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
